hazard_forward_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It closes two gaps in the current 5-stage core: branch select is tied off, and there is no forwarding or load-use detection.
- Keeps an internal shadow of destination-register state for every post-ID stage (EX..WB).
- Produces three kinds of control: registered per-operand forwarding selects for EX, a combinational stall for PC/IF_ID, and a flush on taken branches.
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_forward_unit.sv | 106 ++++++++++
 tb/tb_hazard_forward_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : hazard_forward_unit
// Purpose : Shadow-tracked forwarding selects, load-use stall and branch
//           flush control for the in-order pipeline, with saturating counters.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(STAGES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [ADDR_W-1:0]          id_rd_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_load_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_rs_i,
  input  logic [NUM_SRC-1:0]         id_rs_used_i,
  input  logic                       branch_taken_i,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
  output logic                       stall_o,
  output logic                       flush_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o
);

  logic                 valid_q    [STAGES];
  logic [ADDR_W-1:0]    rd_q       [STAGES];
  logic                 regwrite_q [STAGES];
  logic                 load_q     [STAGES];

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;

  logic [NUM_SRC-1:0]       haz_w;
  logic [NUM_SRC*SEL_W-1:0] code_w;
  logic                     issue_w;

  // Scan deepest to youngest so the lowest matching entry is the one that sticks.
  always_comb begin
    haz_w  = '0;
    code_w = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (id_valid_i && id_rs_used_i[k] && valid_q[i] && regwrite_q[i] &&
            (rd_q[i] == id_rs_i[k*ADDR_W +: ADDR_W]) &&
            (id_rs_i[k*ADDR_W +: ADDR_W] != '0)) begin
          haz_w[k]                  = load_q[i] && (i < LOAD_LAT);
          code_w[k*SEL_W +: SEL_W]  = SEL_W'(i + 1);
        end
      end
    end
  end

  assign flush_o = branch_taken_i;
  assign stall_o = (|haz_w) & ~branch_taken_i;
  assign issue_w = id_valid_i & ~stall_o & ~flush_o;

  always_comb begin
    fwd_sel_d   = issue_w ? code_w : '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_o && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i]    <= 1'b0;
        rd_q[i]       <= '0;
        regwrite_q[i] <= 1'b0;
        load_q[i]     <= 1'b0;
      end
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i]    <= valid_q[i-1];
        rd_q[i]       <= rd_q[i-1];
        regwrite_q[i] <= regwrite_q[i-1];
        load_q[i]     <= load_q[i-1];
      end
      valid_q[0]    <= issue_w;
      rd_q[0]       <= issue_w ? id_rd_i : '0;
      regwrite_q[0] <= issue_w & id_regwrite_i;
      load_q[0]     <= issue_w & id_load_i;
      fwd_sel_q     <= fwd_sel_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign fwd_sel_o   = fwd_sel_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_hazard_forward_unit
// Purpose : Directed self-checking bench for hazard_forward_unit (CNT_W=4).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_load_i;
  logic [9:0]  id_rs_i;
  logic [1:0]  id_rs_used_i;
  logic        branch_taken_i;
  logic [3:0]  fwd_sel_o;
  logic        stall_o;
  logic        flush_o;
  logic [3:0]  stall_cnt_o;
  logic [3:0]  flush_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  hazard_forward_unit #(
    .ADDR_W(5), .STAGES(3), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rd_i        (id_rd_i),
    .id_regwrite_i  (id_regwrite_i),
    .id_load_i      (id_load_i),
    .id_rs_i        (id_rs_i),
    .id_rs_used_i   (id_rs_used_i),
    .branch_taken_i (branch_taken_i),
    .fwd_sel_o      (fwd_sel_o),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // valid, rd, regwrite, load, rs1, rs0, used
  task automatic set_id(input logic v, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic [4:0] rs1, input logic [4:0] rs0,
                        input logic [1:0] used);
    id_valid_i    = v;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_load_i     = ld;
    id_rs_i       = {rs1, rs0};
    id_rs_used_i  = used;
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    branch_taken_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    #2;
    chk("rst_fwd",   32'(fwd_sel_o),   0);
    chk("rst_stall", 32'(stall_o),     0);
    chk("rst_flush", 32'(flush_o),     0);
    chk("rst_scnt",  32'(stall_cnt_o), 0);
    chk("rst_fcnt",  32'(flush_cnt_o), 0);
    tick();
    rst_i = 1'b1;

    // EX-to-EX forward
    set_id(1, 5, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 8, 1, 0, 0, 5, 2'b01);
    chk("exex_nostall", 32'(stall_o), 0);
    tick();
    chk("exex_sel", 32'(fwd_sel_o), 32'h1);
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    chk("bubble_sel", 32'(fwd_sel_o), 0);

    // Load-use, one stall cycle then MEM forward on operand 1
    set_id(1, 6, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 9, 1, 0, 6, 0, 2'b10);
    chk("lu_stall", 32'(stall_o), 1);
    chk("lu_noflush", 32'(flush_o), 0);
    tick();
    chk("lu_scnt", 32'(stall_cnt_o), 1);
    chk("lu_bubble_sel", 32'(fwd_sel_o), 0);
    #1;
    chk("lu_stall_end", 32'(stall_o), 0);
    tick();
    chk("lu_sel", 32'(fwd_sel_o), 32'h8);
    chk("lu_scnt_hold", 32'(stall_cnt_o), 1);

    // x0 never matches, even from a load
    set_id(1, 0, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 11, 0, 0, 0, 0, 2'b11);
    chk("x0_nostall", 32'(stall_o), 0);
    tick();
    chk("x0_sel", 32'(fwd_sel_o), 0);

    // Unused operand matching a fresh load
    set_id(1, 10, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 10, 0, 2'b01);
    chk("unused_nostall", 32'(stall_o), 0);
    tick();
    chk("unused_sel", 32'(fwd_sel_o), 0);

    // Youngest producer wins, then WB-only forward
    set_id(1, 7, 1, 0, 0, 0, 2'b00);
    tick();
    tick();
    set_id(1, 0, 0, 0, 0, 7, 2'b01);
    chk("prio_nostall", 32'(stall_o), 0);
    tick();
    chk("prio_sel", 32'(fwd_sel_o), 32'h1);
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 7, 0, 2'b10);
    tick();
    chk("wb_sel", 32'(fwd_sel_o), 32'hC);

    // Branch while a load-use hazard is present
    set_id(1, 12, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 13, 1, 0, 0, 12, 2'b01);
    branch_taken_i = 1'b1;
    #1;
    chk("br_flush", 32'(flush_o), 1);
    chk("br_nostall", 32'(stall_o), 0);
    tick();
    branch_taken_i = 1'b0;
    chk("br_fcnt", 32'(flush_cnt_o), 1);
    chk("br_scnt", 32'(stall_cnt_o), 1);
    chk("br_sel", 32'(fwd_sel_o), 0);
    set_id(1, 0, 0, 0, 13, 12, 2'b11);
    chk("br_after_nostall", 32'(stall_o), 0);
    chk("br_after_noflush", 32'(flush_o), 0);
    tick();
    chk("br_squash_sel", 32'(fwd_sel_o), 32'h2);

    // Asynchronous reset in the middle of a stall
    set_id(1, 14, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 0, 14, 2'b01);
    chk("mid_stall", 32'(stall_o), 1);
    rst_i = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 0);
    chk("arst_scnt", 32'(stall_cnt_o), 0);
    chk("arst_fcnt", 32'(flush_cnt_o), 0);
    chk("arst_fwd", 32'(fwd_sel_o), 0);
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    rst_i = 1'b1;

    // Twenty load-use stalls against a 4-bit counter
    for (int n = 0; n < 20; n++) begin
      set_id(1, 15, 1, 1, 0, 0, 2'b00);
      tick();
      set_id(1, 0, 0, 0, 0, 15, 2'b01);
      tick();
      tick();
      if (n == 14) chk("sat_reach", 32'(stall_cnt_o), 32'hF);
    end
    chk("sat_hold", 32'(stall_cnt_o), 32'hF);
    chk("sat_fcnt", 32'(flush_cnt_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
